lod_pipe: RTL and testbench
===========================

# lod_pipe

Parametrised, pipelined leading-one detector for the logarithmic-multiplier datapath. Each accepted operand produces a zero flag, sign, leading-one position and left-aligned normalised fraction (bits below the leading one), ready for log-domain addition. Adds over the fixed 8-bit combinational LOD: configurable width, a per-transaction signed (two's-complement magnitude) mode, fraction truncation, two pipeline stages and valid/ready flow control.

## Interface
- WIDTH, 8: operand width, ≥ 2.
- FRAC_W, WIDTH-1: output fraction width, 1 ≤ FRAC_W ≤ WIDTH-1; keeps the top FRAC_W bits of the full fraction.
- POS_W (derived, not overridable): $clog2(WIDTH).

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when in_valid && in_ready.
- in_data  in  WIDTH  operand.
- in_signed  in  1  1 = in_data is two's complement; 0 = unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_zero  out  1  magnitude is zero.
- out_sign  out  1  operand was negative (signed mode only).
- out_pos  out  POS_W  index of leading one of the magnitude.
- out_frac  out  FRAC_W  normalised fraction.

## Operation
- Magnitude: if in_signed && in_data[WIDTH-1], mag = (~in_data + 1) mod 2^WIDTH, sign = 1; otherwise mag = in_data, sign = 0. Most-negative value (1 followed by zeros) yields mag = 2^(WIDTH-1), pos = WIDTH-1, frac = 0, sign = 1.
- pos = highest set bit index of mag; 0 when mag = 0.
- Full fraction (WIDTH-1 bits) = mag[WIDTH-2:0] << (WIDTH-1-pos), truncated to WIDTH-1 bits; out_frac = its top FRAC_W bits (truncation, no rounding).
- mag = 0: out_zero = 1, out_pos = 0, out_frac = 0, out_sign = 0.
- Stage 1 (S1) registers: sign, zero, pos, mag. Stage 2 (S2) registers: sign, zero, pos, frac (shift performed between S1 and S2). Outputs driven directly from S2 registers.
- Flow control: en2 = !s2_valid || out_ready; en1 = !s1_valid || en2; in_ready = en1. S2 loads S1 contents when en2; s2_valid takes s1_valid. S1 loads the input when en1; s1_valid takes in_valid.
- Results leave in acceptance order; no drops, no duplicates.

## Timing
- Latency: operand accepted at edge N appears on out_* (out_valid = 1) after edge N+1, i.e. 2 cycles.
- Throughput: 1 operand/cycle while out_ready = 1.
- out_* stable while out_valid && !out_ready.
- out_ready low: at most 2 operands held (S1, S2); in_ready falls combinationally once both stages are valid and out_ready = 0.
- Simultaneous accept at input and output with both stages full: all stages shift, no bubble.
- in_ready depends combinationally on out_ready (no skid buffer); in_valid must not depend on in_ready.
- Reset (async assert, sync deassert by the system): s1_valid = s2_valid = 0, all data registers 0; out_valid = 0, out_zero = 0, out_sign = 0, out_pos = 0, out_frac = 0, in_ready = 1 during/after reset. In-flight operands are discarded.

## Structure
- Package lod_pkg: function lod_pos_w(width) returning $clog2(width); typedef of the S1 payload struct parameterised via localparams in the module.
- Sub-module lod_prio_enc (combinational, parameter WIDTH): mag in → pos, zero out; instantiated once in front of S1.
- Fraction shifter and two stage registers inline in lod_pipe.

## Test plan
(WIDTH=8, FRAC_W=7 unless noted)
- Unsigned 8'h2C, out_ready=1 → after 2 cycles zero=0, sign=0, pos=5, frac=7'h30.
- Signed 8'hF4 (−12) → pos=3, frac=7'h40, sign=1; signed 8'h80 → pos=7, frac=0, sign=1; unsigned 8'h80 → pos=7, sign=0.
- 8'h00 (both modes) → zero=1, pos=0, frac=0, sign=0; 8'h01 → zero=0, pos=0, frac=0.
- Stream 8'h2C, 8'h03, 8'hFF with out_ready=0 for 4 cycles → in_ready drops after 2 accepted, out_* stay (pos=5, frac=7'h30); release → results in order, third accepted then delivered (8'h03 → pos=1, frac=7'h40).
- FRAC_W=3, WIDTH=16, unsigned 16'h0B00 → pos=11, frac=3'b011.
- Assert rst_n low with both stages valid → out_valid=0 and all outputs 0 immediately; after release no stale result appears, in_ready=1.

Source files
------------

// File: rtl/lod_pkg.sv
// rtl/lod_pkg.sv - shared helpers and types for the pipelined leading-one detector
package lod_pkg;

  function automatic int lod_pos_w(input int width);
    return $clog2(width);
  endfunction

  typedef struct packed {
    logic sign;
    logic zero;
  } lod_flags_t;

endpackage

// File: rtl/lod_prio_enc.sv
// rtl/lod_prio_enc.sv - combinational priority encoder: index of highest set bit
module lod_prio_enc
  import lod_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int POS_W = lod_pos_w(WIDTH)
) (
  input  logic [WIDTH-1:0] mag,
  output logic [POS_W-1:0] pos,
  output logic             zero
);

  // Ascending scan so the highest set bit wins; pos stays 0 for an all-zero input.
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mag[i]) pos = POS_W'(i);
    end
  end

  assign zero = ~|mag;

endmodule

// File: rtl/lod_pipe.sv
// rtl/lod_pipe.sv - two-stage leading-one detector with valid/ready flow control
module lod_pipe
  import lod_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int FRAC_W = WIDTH - 1,
  localparam int POS_W = lod_pos_w(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_zero,
  output logic              out_sign,
  output logic [POS_W-1:0]  out_pos,
  output logic [FRAC_W-1:0] out_frac
);

  localparam logic [POS_W-1:0] TOP_POS = POS_W'(WIDTH - 1);
  localparam int DROP_W = WIDTH - 1 - FRAC_W;

  typedef struct packed {
    lod_flags_t       flags;
    logic [POS_W-1:0] pos;
    logic [WIDTH-1:0] mag;
  } s1_t;

  typedef struct packed {
    lod_flags_t        flags;
    logic [POS_W-1:0]  pos;
    logic [FRAC_W-1:0] frac;
  } s2_t;

  logic             s1_valid, s2_valid;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic             en1, en2;
  logic             in_neg;
  logic [WIDTH-1:0] in_mag;
  logic [POS_W-1:0] enc_pos;
  logic             enc_zero;
  logic [POS_W-1:0] shamt;

  assign en2      = !s2_valid || out_ready;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;

  assign in_neg = in_signed && in_data[WIDTH-1];
  assign in_mag = in_neg ? (~in_data + WIDTH'(1)) : in_data;

  lod_prio_enc #(.WIDTH(WIDTH)) u_prio_enc (
    .mag  (in_mag),
    .pos  (enc_pos),
    .zero (enc_zero)
  );

  always_comb begin
    s1_d            = '0;
    s1_d.flags.sign = in_neg;
    s1_d.flags.zero = enc_zero;
    s1_d.pos        = enc_pos;
    s1_d.mag        = in_mag;
  end

  // Shifting the leading one up to bit WIDTH-1 and then dropping it by the
  // truncating cast leaves the fraction left-aligned in the low FRAC_W bits.
  assign shamt = TOP_POS - s1_q.pos;

  always_comb begin
    s2_d       = '0;
    s2_d.flags = s1_q.flags;
    s2_d.pos   = s1_q.pos;
    s2_d.frac  = FRAC_W'((s1_q.mag << shamt) >> DROP_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (en2) begin
        s2_valid <= s1_valid;
        s2_q     <= s2_d;
      end
      if (en1) begin
        s1_valid <= in_valid;
        s1_q     <= s1_d;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_zero  = s2_q.flags.zero;
  assign out_sign  = s2_q.flags.sign;
  assign out_pos   = s2_q.pos;
  assign out_frac  = s2_q.frac;

endmodule

// File: tb/tb_lod_pipe.sv
// tb/tb_lod_pipe.sv - scoreboard bench for lod_pipe (8/7 and 16/3 configurations)
module tb_lod_pipe;

  typedef struct {
    bit zero;
    bit sign;
    int pos;
    int frac;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, in_signed;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_zero, out_sign;
  logic [2:0] out_pos;
  logic [6:0] out_frac;

  logic        v16, rdy16, s16, ov16, or16, z16, sg16;
  logic [15:0] d16;
  logic [3:0]  p16;
  logic [2:0]  f16;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   mode = 0;

  lod_pipe #(.WIDTH(8), .FRAC_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_zero(out_zero),
    .out_sign(out_sign), .out_pos(out_pos), .out_frac(out_frac)
  );

  lod_pipe #(.WIDTH(16), .FRAC_W(3)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v16), .in_ready(rdy16), .in_data(d16), .in_signed(s16),
    .out_valid(ov16), .out_ready(or16), .out_zero(z16),
    .out_sign(sg16), .out_pos(p16), .out_frac(f16)
  );

  // Reference: magnitude by subtraction from 2^w, position by powers of two,
  // fraction as the remainder scaled up then truncated by integer division.
  function automatic exp_t model(int w, int fw, longint v, bit s);
    exp_t   e;
    longint mag, full;
    e = '{zero: 1'b0, sign: 1'b0, pos: 0, frac: 0};
    if (s && v >= (longint'(1) << (w - 1))) begin
      mag    = (longint'(1) << w) - v;
      e.sign = 1'b1;
    end else begin
      mag = v;
    end
    if (mag == 0) begin
      e.zero = 1'b1;
      return e;
    end
    while ((longint'(1) << (e.pos + 1)) <= mag) e.pos++;
    full   = (mag - (longint'(1) << e.pos)) * (longint'(1) << (w - 1 - e.pos));
    e.frac = int'(full / (longint'(1) << (w - 1 - fw)));
    return e;
  endfunction

  function automatic exp_t mk(bit z, bit s, int p, int f);
    exp_t e;
    e = '{zero: z, sign: s, pos: p, frac: f};
    return e;
  endfunction

  task automatic chk(string name, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_tuple(string name, exp_t got, exp_t exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got zero=%0d sign=%0d pos=%0d frac=%0h expected zero=%0d sign=%0d pos=%0d frac=%0h",
               name, got.zero, got.sign, got.pos, got.frac, exp.zero, exp.sign, exp.pos, exp.frac);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  bit   held = 0;
  exp_t held_v;
  exp_t act;
  exp_t popped;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else if (out_valid) begin
      act = '{zero: out_zero, sign: out_sign, pos: int'(out_pos), frac: int'(out_frac)};
      if (held) chk_tuple("hold_stable", act, held_v);
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pos=%0d frac=%0h expected no output", out_pos, out_frac);
        end else begin
          popped = sb_q.pop_front();
          chk_tuple("scoreboard", act, popped);
        end
        held = 0;
      end else begin
        held   = 1;
        held_v = act;
      end
    end else begin
      held = 0;
    end
  end

  task automatic send(logic [7:0] v, bit s, bit use_exp, exp_t e);
    int n;
    n         = 0;
    in_valid  = 1'b1;
    in_data   = v;
    in_signed = s;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected 1", n);
        in_valid = 1'b0;
        return;
      end
    end
    sb_q.push_back(use_exp ? e : model(8, 7, longint'(v), s));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  task automatic one16(logic [15:0] v, bit s, exp_t e);
    exp_t a;
    @(negedge clk);
    chk("w16_in_ready", rdy16, 1);
    v16 = 1'b1;
    d16 = v;
    s16 = s;
    @(posedge clk);
    #1;
    v16 = 1'b0;
    @(negedge clk);
    chk("w16_latency_early", ov16, 0);
    @(negedge clk);
    chk("w16_valid", ov16, 1);
    a = '{zero: z16, sign: sg16, pos: int'(p16), frac: int'(f16)};
    chk_tuple("w16_result", a, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  exp_t dummy;
  logic [7:0] rv;
  logic [7:0] corners[6] = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h7F, 8'h40};

  initial begin
    dummy     = mk(0, 0, 0, 0);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    v16       = 1'b0;
    d16       = '0;
    s16       = 1'b0;
    or16      = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_sign", out_sign, 0);
    chk("rst_out_pos", out_pos, 0);
    chk("rst_out_frac", out_frac, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'h2C, 0, 1, mk(0, 0, 5, 'h30));
    send(8'hF4, 1, 1, mk(0, 1, 3, 'h40));
    send(8'h80, 1, 1, mk(0, 1, 7, 0));
    send(8'h80, 0, 1, mk(0, 0, 7, 0));
    send(8'h00, 0, 1, mk(1, 0, 0, 0));
    send(8'h00, 1, 1, mk(1, 0, 0, 0));
    send(8'h01, 0, 1, mk(0, 0, 0, 0));
    drain();

    mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(8'h2C, 0, 1, mk(0, 0, 5, 'h30));
    send(8'h03, 0, 1, mk(0, 0, 1, 'h40));
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_signed = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_pos", out_pos, 5);
      chk("stall_out_frac", out_frac, 'h30);
    end
    mode = 0;
    send(8'hFF, 0, 1, mk(0, 0, 7, 'h7F));
    drain();

    mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(8'h2C, 0, 0, dummy);
    send(8'hF4, 1, 0, dummy);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_zero", out_zero, 0);
    chk("arst_out_sign", out_sign, 0);
    chk("arst_out_pos", out_pos, 0);
    chk("arst_out_frac", out_frac, 0);
    chk("arst_in_ready", in_ready, 1);
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mode  = 0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_no_stale", out_valid, 0);
    end
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    mode = 1;
    for (int i = 0; i < 300; i++) begin
      rv = (i % 4 == 0) ? corners[$urandom_range(0, 5)] : 8'($urandom_range(0, 255));
      send(rv, 1'($urandom_range(0, 1)), 0, dummy);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    mode = 0;
    drain();

    one16(16'h0B00, 0, mk(0, 0, 11, 3));
    one16(16'h8000, 1, mk(0, 1, 15, 0));
    for (int i = 0; i < 12; i++) begin
      logic [15:0] r;
      logic        s;
      r = 16'($urandom_range(0, 65535));
      s = 1'($urandom_range(0, 1));
      one16(r, s, model(16, 3, longint'(r), s));
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
